// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
//
// Two-master, one-slave Wishbone arbiter. It shares a single-port word RAM
// between the instruction fetch port (m0) and the load/store port (m1).
// Arbitration is round-robin with one transfer per grant. A registered grant
// (state + owner) drives a combinational mux onto the slave bus. The slave ack
// is routed back only to the owning master. Every ack is followed by one
// mandatory IDLE cycle, so the slave sees stb drop between transfers.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN):
//   When the macro is defined, a grant with no ack for TIMEOUT_CYCLES cycles is
//   released. The owner's err output pulses for the last of those cycles.
//   When the macro is undefined, both err outputs are tied low and a hung
//   slave holds the grant indefinitely.
//
// Parameters:
//   ADDR_WIDTH      byte-address width; the word address bus is [ADDR_WIDTH-1:2]
//   TIMEOUT_CYCLES  GRANT cycles without ack before the error release (>= 2);
//                   only used when WB_ARB_TIMEOUT_EN is defined
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   mN_wb_adr_i/dat_i/we_i/sel_i master request fields (N = 0, 1)
//   mN_wb_cyc_i/stb_i            master cycle / strobe
//   mN_wb_dat_o                  slave read data, fanned out to both masters
//   mN_wb_ack_o                  slave ack, gated to the owning master
//   mN_wb_err_o                  timeout error pulse (0 without the feature)
//   s_wb_adr_o/dat_o/we_o/sel_o  muxed slave request fields
//   s_wb_cyc_o/stb_o             high while a grant is active
//   s_wb_ack_i/dat_i             slave ack and read data
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  // master 0 (instruction fetch)
  input  logic [ADDR_WIDTH-1:2] m0_wb_adr_i,
  input  logic [31:0]           m0_wb_dat_i,
  output logic [31:0]           m0_wb_dat_o,
  input  logic                  m0_wb_we_i,
  input  logic [3:0]            m0_wb_sel_i,
  input  logic                  m0_wb_cyc_i,
  input  logic                  m0_wb_stb_i,
  output logic                  m0_wb_ack_o,
  output logic                  m0_wb_err_o,
  // master 1 (load/store)
  input  logic [ADDR_WIDTH-1:2] m1_wb_adr_i,
  input  logic [31:0]           m1_wb_dat_i,
  output logic [31:0]           m1_wb_dat_o,
  input  logic                  m1_wb_we_i,
  input  logic [3:0]            m1_wb_sel_i,
  input  logic                  m1_wb_cyc_i,
  input  logic                  m1_wb_stb_i,
  output logic                  m1_wb_ack_o,
  output logic                  m1_wb_err_o,
  // slave
  output logic [ADDR_WIDTH-1:2] s_wb_adr_o,
  output logic [31:0]           s_wb_dat_o,
  output logic                  s_wb_we_o,
  output logic [3:0]            s_wb_sel_o,
  output logic                  s_wb_cyc_o,
  output logic                  s_wb_stb_o,
  input  logic                  s_wb_ack_i,
  input  logic [31:0]           s_wb_dat_i
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t r_state;
  logic   r_owner;
  logic   r_last;

  logic   w_req0;
  logic   w_req1;
  logic   w_grant;
  logic   w_next_owner;
  logic   w_timeout;

  assign w_req0  = m0_wb_cyc_i & m0_wb_stb_i;
  assign w_req1  = m1_wb_cyc_i & m1_wb_stb_i;
  assign w_grant = (r_state == ST_GRANT);

  // On a tie the master that did not win last time goes next. last resets to
  // 1, so m0 wins the first tie after reset.
  always_comb begin
    w_next_owner = 1'b0;
    if (w_req0 && w_req1) begin
      w_next_owner = ~r_last;
    end else begin
      w_next_owner = w_req1;
    end
  end

  // An out-of-range TIMEOUT_CYCLES shows up as this named block in the
  // elaborated hierarchy.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_below_min
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // An ack in the same cycle takes priority over the timeout.
  assign w_timeout   = w_grant & ~s_wb_ack_i & (r_count == TO_LAST);
  assign m0_wb_err_o = w_timeout & ~r_owner;
  assign m1_wb_err_o = w_timeout &  r_owner;
`else
  assign w_timeout   = 1'b0;
  assign m0_wb_err_o = 1'b0;
  assign m1_wb_err_o = 1'b0;
`endif

  // Arbiter FSM. The grant ends on ack (or on timeout when that feature is
  // built in). GRANT always returns to IDLE, which gives the bubble cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      r_count <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req0 || w_req1) begin
            r_state <= ST_GRANT;
            r_owner <= w_next_owner;
            r_last  <= w_next_owner;
`ifdef WB_ARB_TIMEOUT_EN
            r_count <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (s_wb_ack_i || w_timeout) begin
            r_state <= ST_IDLE;
          end
`ifdef WB_ARB_TIMEOUT_EN
          if (!s_wb_ack_i) begin
            r_count <= r_count + CW'(1);
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Slave-side mux follows the owner register. In IDLE stb is low, so
  // adr/dat/sel are don't-care, but we is forced low.
  assign s_wb_cyc_o = w_grant;
  assign s_wb_stb_o = w_grant;
  assign s_wb_adr_o = r_owner ? m1_wb_adr_i : m0_wb_adr_i;
  assign s_wb_dat_o = r_owner ? m1_wb_dat_i : m0_wb_dat_i;
  assign s_wb_sel_o = r_owner ? m1_wb_sel_i : m0_wb_sel_i;
  assign s_wb_we_o  = w_grant & (r_owner ? m1_wb_we_i : m0_wb_we_i);

  // Read data goes to both masters; each master qualifies it with its ack.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  assign m0_wb_ack_o = s_wb_ack_i & w_grant & ~r_owner;
  assign m1_wb_ack_o = s_wb_ack_i & w_grant &  r_owner;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed testbench for wb_arbiter2. It includes a registered one-cycle-latency
// RAM slave model with byte selects and a "hang" switch that suppresses ack.
module tb_wb_arbiter2;

  localparam int AW = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:2] m0_adr, m1_adr, s_adr;
  logic [31:0]   m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
  logic          m0_we, m1_we, s_we;
  logic [3:0]    m0_sel, m1_sel, s_sel;
  logic          m0_cyc, m0_stb, m1_cyc, m1_stb;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic          s_cyc, s_stb, s_ack;

  int total = 0;
  int bad   = 0;

  logic        slave_hang = 1'b0;
  logic [31:0] mem [0:255];

  wb_arbiter2 #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .m0_wb_adr_i (m0_adr),
    .m0_wb_dat_i (m0_dat_w),
    .m0_wb_dat_o (m0_dat_r),
    .m0_wb_we_i  (m0_we),
    .m0_wb_sel_i (m0_sel),
    .m0_wb_cyc_i (m0_cyc),
    .m0_wb_stb_i (m0_stb),
    .m0_wb_ack_o (m0_ack),
    .m0_wb_err_o (m0_err),
    .m1_wb_adr_i (m1_adr),
    .m1_wb_dat_i (m1_dat_w),
    .m1_wb_dat_o (m1_dat_r),
    .m1_wb_we_i  (m1_we),
    .m1_wb_sel_i (m1_sel),
    .m1_wb_cyc_i (m1_cyc),
    .m1_wb_stb_i (m1_stb),
    .m1_wb_ack_o (m1_ack),
    .m1_wb_err_o (m1_err),
    .s_wb_adr_o  (s_adr),
    .s_wb_dat_o  (s_dat_w),
    .s_wb_we_o   (s_we),
    .s_wb_sel_o  (s_sel),
    .s_wb_cyc_o  (s_cyc),
    .s_wb_stb_o  (s_stb),
    .s_wb_ack_i  (s_ack),
    .s_wb_dat_i  (s_dat_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered RAM slave: ack toggles, so back-to-back strobes are not
  // acknowledged twice.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack   <= 1'b0;
      s_dat_r <= '0;
    end else begin
      s_ack   <= s_cyc & s_stb & ~s_ack & ~slave_hang;
      s_dat_r <= mem[s_adr[9:2]];
      if (s_cyc && s_stb && s_we && !s_ack && !slave_hang) begin
        for (int b = 0; b < 4; b++) begin
          if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] <= s_dat_w[8*b +: 8];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic [AW-1:2] adr, input logic [31:0] dat,
                          input logic we, input logic [3:0] sel, input logic req);
    m0_adr = adr; m0_dat_w = dat; m0_we = we; m0_sel = sel; m0_cyc = req; m0_stb = req;
  endtask

  task automatic drive_m1(input logic [AW-1:2] adr, input logic [31:0] dat,
                          input logic we, input logic [3:0] sel, input logic req);
    m1_adr = adr; m1_dat_w = dat; m1_we = we; m1_sel = sel; m1_cyc = req; m1_stb = req;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_m0('0, '0, 1'b0, 4'h0, 1'b0);
    drive_m1('0, '0, 1'b0, 4'h0, 1'b0);
    repeat (2) tick();
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL reset_cyc: got %b expected 0", s_cyc); end
    total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b expected 0", s_stb); end
    total++; if ({m0_ack, m1_ack} !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b expected 00", {m0_ack, m1_ack}); end
    total++; if ({m0_err, m1_err} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b expected 00", {m0_err, m1_err}); end
    total++; if (s_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b expected 0", s_we); end
    rst_n = 1'b1;
    tick();
    $display("reset done");
  endtask

  task automatic test_single_read();
    mem[8'h04] = 32'hDEADBEEF;
    drive_m0(14'h0004, '0, 1'b0, 4'hF, 1'b1);
    tick();
    total++; if (s_stb !== 1'b1 || s_cyc !== 1'b1) begin bad++; $display("FAIL read_grant: got stb=%b cyc=%b expected 1 1", s_stb, s_cyc); end
    total++; if (s_adr !== 14'h0004) begin bad++; $display("FAIL read_adr: got %h expected 0004", s_adr); end
    total++; if (m0_ack !== 1'b0) begin bad++; $display("FAIL read_early_ack: got %b expected 0", m0_ack); end
    tick();
    total++; if (m0_ack !== 1'b1) begin bad++; $display("FAIL read_ack: got %b expected 1", m0_ack); end
    total++; if (m0_dat_r !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data: got %h expected deadbeef", m0_dat_r); end
    total++; if (m1_ack !== 1'b0) begin bad++; $display("FAIL read_m1_ack: got %b expected 0", m1_ack); end
    drive_m0(14'h0004, '0, 1'b0, 4'hF, 1'b0);
    tick();
    total++; if (s_stb !== 1'b0 || s_we !== 1'b0) begin bad++; $display("FAIL read_bubble: got stb=%b we=%b expected 0 0", s_stb, s_we); end
    $display("xfer m0 read adr=0004 data=%h", m0_dat_r);
  endtask

  task automatic test_round_robin();
    logic [AW-1:2] exp_adr;
    logic          exp_owner;
    // fresh reset so the first tie goes to m0
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    drive_m0(14'h0010, '0, 1'b0, 4'hF, 1'b1);
    drive_m1(14'h0020, '0, 1'b0, 4'hF, 1'b1);
    for (int k = 0; k < 6; k++) begin
      exp_owner = k[0];
      exp_adr   = exp_owner ? 14'h0020 : 14'h0010;
      tick();
      total++; if (s_stb !== 1'b1 || s_adr !== exp_adr) begin bad++; $display("FAIL rr_grant%0d: got stb=%b adr=%h expected 1 %h", k, s_stb, s_adr, exp_adr); end
      tick();
      total++; if ({m1_ack, m0_ack} !== (exp_owner ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_ack%0d: got m1m0=%b expected %b", k, {m1_ack, m0_ack}, exp_owner ? 2'b10 : 2'b01); end
      tick();
      total++; if (s_stb !== 1'b0 || s_we !== 1'b0 || {m1_ack, m0_ack} !== 2'b00) begin bad++; $display("FAIL rr_bubble%0d: got stb=%b we=%b ack=%b expected 0 0 00", k, s_stb, s_we, {m1_ack, m0_ack}); end
      $display("xfer contended grant %0d to m%0d", k, exp_owner);
    end
    drive_m0(14'h0010, '0, 1'b0, 4'hF, 1'b0);
    drive_m1(14'h0020, '0, 1'b0, 4'hF, 1'b0);
    tick();
  endtask

  task automatic test_write_read();
    mem[8'h08] = 32'hAAAAAAAA;
    drive_m1(14'h0008, 32'h11223344, 1'b1, 4'b0101, 1'b1);
    tick();
    total++; if (s_we !== 1'b1 || s_adr !== 14'h0008 || s_dat_w !== 32'h11223344 || s_sel !== 4'b0101) begin
      bad++; $display("FAIL wr_mux: got we=%b adr=%h dat=%h sel=%b expected 1 0008 11223344 0101", s_we, s_adr, s_dat_w, s_sel); end
    tick();
    total++; if ({m1_ack, m0_ack} !== 2'b10) begin bad++; $display("FAIL wr_ack: got m1m0=%b expected 10", {m1_ack, m0_ack}); end
    drive_m1(14'h0008, 32'h11223344, 1'b1, 4'b0101, 1'b0);
    tick();
    total++; if (s_we !== 1'b0) begin bad++; $display("FAIL wr_idle_we: got %b expected 0", s_we); end
    $display("xfer m1 write adr=0008 data=11223344 sel=0101");
    drive_m0(14'h0008, '0, 1'b0, 4'hF, 1'b1);
    tick();
    total++; if (s_we !== 1'b0 || s_stb !== 1'b1) begin bad++; $display("FAIL rd8_grant: got we=%b stb=%b expected 0 1", s_we, s_stb); end
    tick();
    total++; if (m0_ack !== 1'b1 || m0_dat_r !== 32'hAA22AA44) begin bad++; $display("FAIL rd8_data: got ack=%b dat=%h expected 1 aa22aa44", m0_ack, m0_dat_r); end
    drive_m0(14'h0008, '0, 1'b0, 4'hF, 1'b0);
    tick();
    total++; if (s_we !== 1'b0) begin bad++; $display("FAIL rd8_idle_we: got %b expected 0", s_we); end
    $display("xfer m0 read adr=0008 data=%h", m0_dat_r);
  endtask

  task automatic test_async_reset();
    drive_m1(14'h0003, '0, 1'b0, 4'hF, 1'b1);
    tick();
    total++; if (s_stb !== 1'b1) begin bad++; $display("FAIL ar_grant: got stb=%b expected 1", s_stb); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (s_stb !== 1'b0 || s_cyc !== 1'b0 || {m1_ack, m0_ack} !== 2'b00) begin
      bad++; $display("FAIL ar_drop: got stb=%b cyc=%b ack=%b expected 0 0 00", s_stb, s_cyc, {m1_ack, m0_ack}); end
    tick();
    total++; if (m1_ack !== 1'b0 || s_stb !== 1'b0) begin bad++; $display("FAIL ar_hold: got ack=%b stb=%b expected 0 0", m1_ack, s_stb); end
    rst_n = 1'b1;
    drive_m0(14'h0005, '0, 1'b0, 4'hF, 1'b1);
    tick();
    total++; if (s_stb !== 1'b1 || s_adr !== 14'h0005) begin bad++; $display("FAIL ar_tie: got stb=%b adr=%h expected 1 0005", s_stb, s_adr); end
    tick();
    total++; if ({m1_ack, m0_ack} !== 2'b01) begin bad++; $display("FAIL ar_tie_ack: got m1m0=%b expected 01", {m1_ack, m0_ack}); end
    drive_m0(14'h0005, '0, 1'b0, 4'hF, 1'b0);
    drive_m1(14'h0003, '0, 1'b0, 4'hF, 1'b0);
    tick();
    $display("xfer reset mid-transfer then m0 granted on tie");
  endtask

  task automatic test_timeout();
    slave_hang = 1'b1;
    drive_m0(14'h0006, '0, 1'b0, 4'hF, 1'b1);
    tick();
    drive_m1(14'h0007, '0, 1'b0, 4'hF, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      total++; if ({m1_err, m0_err} !== 2'b00 || s_stb !== 1'b1) begin bad++; $display("FAIL to_wait%0d: got err=%b stb=%b expected 00 1", c, {m1_err, m0_err}, s_stb); end
      tick();
    end
`ifdef WB_ARB_TIMEOUT_EN
    total++; if ({m1_err, m0_err} !== 2'b01) begin bad++; $display("FAIL to_err: got m1m0=%b expected 01", {m1_err, m0_err}); end
    drive_m0(14'h0006, '0, 1'b0, 4'hF, 1'b0);
    tick();
    total++; if (s_stb !== 1'b0 || {m1_err, m0_err} !== 2'b00) begin bad++; $display("FAIL to_idle: got stb=%b err=%b expected 0 00", s_stb, {m1_err, m0_err}); end
    slave_hang = 1'b0;
    tick();
    total++; if (s_stb !== 1'b1 || s_adr !== 14'h0007) begin bad++; $display("FAIL to_next: got stb=%b adr=%h expected 1 0007", s_stb, s_adr); end
    tick();
    total++; if (m1_ack !== 1'b1) begin bad++; $display("FAIL to_next_ack: got %b expected 1", m1_ack); end
    drive_m1(14'h0007, '0, 1'b0, 4'hF, 1'b0);
    tick();
    $display("xfer m0 timeout, m1 granted next");
`else
    for (int c = 0; c < 20; c++) begin
      total++; if ({m1_err, m0_err} !== 2'b00 || s_stb !== 1'b1 || s_adr !== 14'h0006) begin
        bad++; $display("FAIL hang%0d: got err=%b stb=%b adr=%h expected 00 1 0006", c, {m1_err, m0_err}, s_stb, s_adr); end
      tick();
    end
    drive_m0(14'h0006, '0, 1'b0, 4'hF, 1'b0);
    drive_m1(14'h0007, '0, 1'b0, 4'hF, 1'b0);
    slave_hang = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    $display("xfer hung slave holds m0 grant");
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
